// File: rtl/cpu8_program_sequencer.sv
// Program sequencer for the 8-bit accumulator CPU.
// Loads a short program over a valid/ready byte port and replays it one byte per clock, once or looping.
module cpu8_program_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [7:0]        instr_out,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   LEN_FULL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;
  localparam logic [ADDR_W-1:0] PC_ONE   = 1;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // Program storage is deliberately not reset; prog_len=0 guards stale contents.
  logic [7:0]        mem [DEPTH];
  logic              mem_we;
  logic              ready;
  logic              last_byte;
  logic [ADDR_W-1:0] pc_inc;

  assign ready     = (state_q == S_LOAD) && (prog_len_q < LEN_FULL);
  assign pc_inc    = pc_q + PC_ONE;
  assign last_byte = (({1'b0, pc_q} + LEN_ONE) == prog_len_q);

  always_comb begin
    state_d    = state_q;
    prog_len_d = prog_len_q;
    pc_d       = pc_q;
    instr_d    = 8'h00;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d    = S_LOAD;
          prog_len_d = '0;
        end else if (start && (prog_len_q != '0)) begin
          state_d = S_RUN;
          pc_d    = '0;
          instr_d = mem[0];
          valid_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (load_valid && ready) begin
          mem_we     = 1'b1;
          prog_len_d = prog_len_q + LEN_ONE;
        end
        if (!load_en) state_d = S_IDLE;
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end else if (last_byte) begin
          pc_d = '0;
          if (loop_en) begin
            instr_d = mem[0];
            valid_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          pc_d    = pc_inc;
          instr_d = mem[pc_inc];
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      prog_len_q <= '0;
      pc_q       <= '0;
      instr_q    <= 8'h00;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_len_q <= prog_len_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[prog_len_q[ADDR_W-1:0]] <= load_data;
  end

  assign load_ready  = ready;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign prog_len    = prog_len_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_cpu8_program_sequencer.sv
// Scoreboard bench for cpu8_program_sequencer: a program-list model predicts every
// replayed byte and done pulse; a negedge monitor pops and compares them.
module tb_cpu8_program_sequencer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_en, load_valid, start, stop, loop_en;
  logic [7:0]        load_data;
  logic              load_ready;
  logic [7:0]        instr_out;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   prog_len;
  logic              busy, done;

  cpu8_program_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .start(start), .stop(stop), .loop_en(loop_en),
    .instr_out(instr_out), .instr_valid(instr_valid), .pc(pc),
    .prog_len(prog_len), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]        instr;
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic              done;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_prog[$];
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] i, input logic v, input int p, input logic d);
    exp_t e;
    e.instr = i;
    e.valid = v;
    e.pc    = p[ADDR_W-1:0];
    e.done  = d;
    return e;
  endfunction

  // Monitor: every cycle that carries a byte or a done pulse must match the next expectation.
  always @(negedge clk) begin
    if (rst_n && (instr_valid || done)) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {instr_out, instr_valid, pc, done}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out{instr,valid,pc,done}", {instr_out, instr_valid, pc, done},
            {e.instr, e.valid, e.pc, e.done});
        $display("out instr=%02h pc=%0d valid=%0b done=%0b", instr_out, pc, instr_valid, done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input logic [7:0] bytes[$], input bit gaps, input bit exit_with_last);
    bit last;
    load_en = 1'b1;
    tick();
    model_prog.delete();
    chk("len_clear", prog_len, 0);
    for (int i = 0; i < bytes.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          load_valid = 1'b0;
          chk("load_ready_gap", load_ready, model_prog.size() < DEPTH);
          tick();
        end
      end
      last       = (i == bytes.size() - 1) && exit_with_last;
      load_valid = 1'b1;
      load_data  = bytes[i];
      if (last) load_en = 1'b0;
      chk("load_ready", load_ready, model_prog.size() < DEPTH);
      if (model_prog.size() < DEPTH) model_prog.push_back(bytes[i]);
      tick();
    end
    load_valid = 1'b0;
    if (load_en) begin
      load_en = 1'b0;
      tick();
    end
    chk("prog_len", prog_len, model_prog.size());
    chk("busy_after_load", busy, 0);
    $display("load n_sent=%0d accepted=%0d", bytes.size(), model_prog.size());
  endtask

  // stop_after=0 means run to completion (non-looping only); otherwise stop after that many bytes.
  task automatic run_prog(input bit loop, input int stop_after);
    int n, k;
    n = model_prog.size();
    loop_en = loop;
    if (n == 0) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("empty_start_busy", busy, 0);
      chk("empty_start_valid", instr_valid, 0);
      tick();
      return;
    end
    k = (stop_after > 0) ? stop_after : n;
    for (int i = 0; i < k; i++) sb.push_back(mk(model_prog[i % n], 1'b1, i % n, 1'b0));
    if (stop_after == 0) sb.push_back(mk(8'h00, 1'b0, 0, 1'b1));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (k - 1) tick();
    if (stop_after > 0) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_instr", instr_out, 0);
      chk("stop_valid", instr_valid, 0);
      chk("stop_busy", busy, 0);
    end else begin
      tick();
      tick();
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
    end
    tick();
    chk("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    logic [7:0] bytes[$];
    int         len;
    bit         lp;
    int         sa;

    rst_n = 1'b0; load_en = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("rst_instr", instr_out, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_len", prog_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", load_ready, 0);
    run_prog(1'b0, 0);

    bytes = '{8'h31, 8'h12, 8'h02};
    load_prog(bytes, 1'b0, 1'b0);
    run_prog(1'b0, 0);

    bytes.delete();
    for (int i = 1; i <= 17; i++) bytes.push_back(8'(i));
    load_prog(bytes, 1'b0, 1'b0);
    run_prog(1'b0, 0);

    bytes = '{8'hA1, 8'hB2};
    load_prog(bytes, 1'b0, 1'b0);
    run_prog(1'b1, 7);

    bytes = '{8'h11, 8'h22, 8'h33};
    load_prog(bytes, 1'b0, 1'b1);
    bytes = '{8'h45};
    load_prog(bytes, 1'b0, 1'b0);
    run_prog(1'b0, 0);

    for (int t = 0; t < 14; t++) begin
      len = $urandom_range(0, 18);
      bytes.delete();
      for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
      load_prog(bytes, 1'($urandom), (len > 0) && 1'($urandom));
      lp = 1'($urandom);
      if (lp) sa = $urandom_range(1, 40);
      else if ($urandom_range(0, 1) == 0) sa = 0;
      else sa = $urandom_range(1, (len > 0) ? ((len > DEPTH) ? DEPTH : len) : 1);
      run_prog(lp, sa);
    end

    bytes = '{8'h5A, 8'h6B, 8'h7C};
    load_prog(bytes, 1'b0, 1'b0);
    sb.push_back(mk(8'h5A, 1'b1, 0, 1'b0));
    sb.push_back(mk(8'h6B, 1'b1, 1, 1'b0));
    sb.push_back(mk(8'h7C, 1'b1, 2, 1'b0));
    loop_en = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    model_prog.delete();
    chk("arst_instr", instr_out, 0);
    chk("arst_valid", instr_valid, 0);
    chk("arst_pc", pc, 0);
    chk("arst_len", prog_len, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", load_ready, 0);
    #3 rst_n = 1'b1;
    tick();
    run_prog(1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu8_program_sequencer.md
# cpu8_program_sequencer

Instruction source for the 8-bit accumulator CPU. It sits directly upstream of the CPU and drives the CPU's 8-bit input port: opcode in bits [3:0], operand nibble in [7:4]. It holds a short program loaded over a valid/ready byte port, then replays it one byte per clock, either once or looping. While not running it drives 0x00, which the CPU treats as a no-op because opcode 0 is undefined.

## Interface
- DEPTH, 16, program memory depth in bytes; must be a power of 2, minimum 2.
- ADDR_W, 4, equal to log2(DEPTH).
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_en  input  1  level signal; requests or holds load mode.
- load_valid  input  1  a program byte is present on load_data.
- load_data  input  8  program byte: opcode [3:0], operand [7:4].
- load_ready  output  1  sequencer can accept a byte this cycle.
- start  input  1  begin replay (sampled in IDLE only).
- stop  input  1  abort replay (sampled in RUN only).
- loop_en  input  1  1 = wrap to byte 0 after the last byte; 0 = finish.
- instr_out  output  8  instruction byte to the CPU; registered.
- instr_valid  output  1  instr_out carries a program byte.
- pc  output  ADDR_W  index of the byte currently on instr_out.
- prog_len  output  ADDR_W+1  number of bytes loaded, 0..DEPTH.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse when a non-looping replay completes.

## Operation
- The FSM has three states: IDLE, LOAD and RUN. Reset forces IDLE.
- IDLE
  - load_en=1: go to LOAD and clear prog_len to 0. Any previous program is discarded.
  - Otherwise, start=1 with prog_len≠0: go to RUN. On the same edge set instr_out←mem[0], pc←0, instr_valid←1.
  - start=1 with prog_len=0: ignored; stay in IDLE.
  - load_en has priority over start.
- LOAD
  - load_ready = (state==LOAD) && (prog_len<DEPTH). This is combinational from registered state.
  - Transfer happens on an edge with load_valid && load_ready: mem[prog_len[ADDR_W-1:0]]←load_data, prog_len←prog_len+1.
  - When prog_len reaches DEPTH, load_ready drops. Further valid bytes are dropped; there is no overflow wrap.
  - load_en=0: go to IDLE. A transfer on that same edge is still accepted.
- RUN
  - stop=1 has the highest priority. Next state is IDLE with instr_out←0x00, instr_valid←0, pc←0, and no done pulse.
  - If pc = prog_len−1 and loop_en=1: pc←0, instr_out←mem[0]. The wrap is seamless, with no bubble.
  - If pc = prog_len−1 and loop_en=0: go to IDLE with instr_out←0x00, instr_valid←0, pc←0, and done←1 for exactly one cycle.
  - Otherwise: pc←pc+1, instr_out←mem[pc+1].
  - loop_en is sampled only at the last-byte edge, so changing it mid-run takes effect on the current pass.
  - load_en and start are ignored in RUN.
- Outside RUN, instr_out is 0x00 and instr_valid is 0.
- Memory contents are not reset. prog_len is reset to 0, so stale memory can never be replayed.

## Timing
- Reset values: instr_out=0x00, instr_valid=0, pc=0, prog_len=0, busy=0, done=0, load_ready=0. The asynchronous reset applies immediately, including mid-load or mid-run.
- Start latency: the first program byte appears on instr_out in the cycle after the edge that samples start.
- Throughput: one byte per cycle in RUN. A non-looping program of N bytes keeps instr_valid high for exactly N cycles; done is high in the following cycle.
- Load throughput: one byte per cycle while load_ready=1. The first transfer can occur on the edge after LOAD is entered.
- stop latency: instr_out is 0x00 in the cycle after stop is sampled.
- busy, instr_valid and done are registered outputs. load_ready is combinational from state and prog_len only, never from load_valid.

## Test plan
- Reset: pulse rst_n low asynchronously, between clock edges. All outputs read 0 immediately. Then start=1 → remains IDLE, instr_valid=0.
- Single pass: load 0x31, 0x12, 0x02, then start with loop_en=0.
  - instr_out must be 0x31, 0x12, 0x02 on three consecutive cycles, with pc=0, 1, 2 and instr_valid=1.
  - Next cycle: instr_out=0x00, done=1.
  - Cycle after: done=0, busy=0.
- Full memory: hold load_valid for 17 bytes (0x01..0x11) with DEPTH=16.
  - load_ready falls after the 16th transfer and prog_len=16.
  - Replay ends with 0x10; byte 0x11 never appears.
- Loop and stop: load 0xA1, 0xB2 with loop_en=1 and start.
  - Output must be 0xA1, 0xB2, 0xA1, 0xB2, … with no gap.
  - Assert stop for one cycle: next cycle instr_out=0x00, instr_valid=0, done never pulses.
- Reload: after a 3-byte program, re-enter LOAD and load 1 byte 0x45, then start. Exactly one cycle of 0x45 is output, followed by a done pulse.
- Reset mid-run: during a looping replay, drop rst_n. Outputs clear asynchronously and prog_len=0. A subsequent start without reloading produces no output.
